vga_tile_renderer: RTL and testbench

Pixel-colour stage directly downstream of the VGA timing generator. It consumes `hcount`, `vcount`, `bright` and the raw `hsync`/`vsync`, and produces 24-bit RGB with delay-matched sync/blank for the DAC. Pixels are looked up in a 40×30 map of 16×16 solid-colour cells, each stored as RGB332, and a blinking cursor outline is overlaid on one selected cell. The game CPU writes the cell map through a write port; the map is cleared by a hardware sweep after reset.

---
 rtl/vga_tile_renderer.sv | 188 ++++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel colour stage: 40x30 RGB332 cell map, cursor overlay,
// 2-clk colour/sync pipeline and a post-reset clear sweep of the map.
module vga_tile_renderer #(
    parameter int          H_OFFSET     = 160,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] CURSOR_COLOR = 24'hFFFFFF,
    parameter int          BLINK_LOG2   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        bright,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_n_out,
    output logic        wr_err,
    output logic        clr_busy
);

    localparam int          FW     = BLINK_LOG2 + 1;
    localparam logic [9:0]  HOFF   = 10'(H_OFFSET);
    localparam logic [10:0] NCELL  = 11'd1200;
    localparam logic [10:0] LAST   = 11'd1199;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [10:0]   clr_addr_q, clr_addr_d;
    logic          wr_err_q, wr_err_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          vsync_prev_q, vsync_prev_d;

    logic          hsync_s0_q, hsync_s0_d;
    logic          vsync_s0_q, vsync_s0_d;
    logic          bright_s0_q, bright_s0_d;
    logic          in_map_s0_q, in_map_s0_d;
    logic          cursor_s0_q, cursor_s0_d;

    logic [23:0]   rgb_q, rgb_d;
    logic          hsync_o_q, hsync_o_d;
    logic          vsync_o_q, vsync_o_d;
    logic          blank_o_q, blank_o_d;

    logic [7:0]    mem [0:1199];
    logic [7:0]    rd_data_q;
    logic          mem_we;
    logic [10:0]   mem_waddr;
    logic [7:0]    mem_wdata;

    logic [9:0]    x;
    logic [5:0]    col;
    logic [4:0]    row;
    logic [10:0]   rd_addr;
    logic          edge_px;
    logic          unused_vbit;

    assign unused_vbit = vcount[9];

    always_comb begin
        x       = hcount - HOFF;
        col     = x[9:4];
        row     = vcount[8:4];
        // row*40 + col without a multiplier
        rd_addr = {1'b0, row, 5'd0} + {3'd0, row, 3'd0} + {5'd0, col};
        edge_px = (x[3:0] == 4'h0) | (x[3:0] == 4'hF)
                | (vcount[3:0] == 4'h0) | (vcount[3:0] == 4'hF);

        vsync_prev_d = vsync_in;
        frame_d      = frame_q
                     + {{(FW-1){1'b0}}, vsync_prev_q & ~vsync_in};

        hsync_s0_d  = hsync_in;
        vsync_s0_d  = vsync_in;
        bright_s0_d = bright;
        in_map_s0_d = bright & (col < 6'd40) & (row < 5'd30);
        cursor_s0_d = cursor_en & ~frame_q[BLINK_LOG2]
                    & (col == cursor_col) & (row == cursor_row)
                    & edge_px;
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_err_d   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        if (state_q == S_CLEAR) begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = 8'h00;
            clr_addr_d = clr_addr_q + 11'd1;
            wr_err_d   = wr_en;
            if (clr_addr_q == LAST) begin
                state_d = S_RUN;
            end
        end else if (wr_en) begin
            if (wr_addr < NCELL) begin
                mem_we = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        hsync_o_d = hsync_s0_q;
        vsync_o_d = vsync_s0_q;
        blank_o_d = bright_s0_q;
        if (!bright_s0_q) begin
            rgb_d = 24'h000000;
        end else if (state_q == S_CLEAR) begin
            rgb_d = BG_COLOR;
        end else if (cursor_s0_q) begin
            rgb_d = CURSOR_COLOR;
        end else if (in_map_s0_q) begin
            rgb_d = {rd_data_q[7:5], rd_data_q[7:5], rd_data_q[7:6],
                     rd_data_q[4:2], rd_data_q[4:2], rd_data_q[4:3],
                     {4{rd_data_q[1:0]}}};
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // Read returns the pre-write contents on an address collision
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= 11'd0;
            wr_err_q     <= 1'b0;
            frame_q      <= '0;
            vsync_prev_q <= 1'b1;
            hsync_s0_q   <= 1'b1;
            vsync_s0_q   <= 1'b1;
            bright_s0_q  <= 1'b0;
            in_map_s0_q  <= 1'b0;
            cursor_s0_q  <= 1'b0;
            rgb_q        <= 24'h000000;
            hsync_o_q    <= 1'b1;
            vsync_o_q    <= 1'b1;
            blank_o_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wr_err_q     <= wr_err_d;
            frame_q      <= frame_d;
            vsync_prev_q <= vsync_prev_d;
            hsync_s0_q   <= hsync_s0_d;
            vsync_s0_q   <= vsync_s0_d;
            bright_s0_q  <= bright_s0_d;
            in_map_s0_q  <= in_map_s0_d;
            cursor_s0_q  <= cursor_s0_d;
            rgb_q        <= rgb_d;
            hsync_o_q    <= hsync_o_d;
            vsync_o_q    <= vsync_o_d;
            blank_o_q    <= blank_o_d;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign hsync_out   = hsync_o_q;
    assign vsync_out   = vsync_o_q;
    assign blank_n_out = blank_o_q;
    assign wr_err      = wr_err_q;
    assign clr_busy    = (state_q == S_CLEAR);

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer: directed steps plus randomized pixels and
// sync sweep, checked against an arithmetic model of the tile map.
module tb_vga_tile_renderer;

    localparam logic [23:0] BG  = 24'h102030;
    localparam logic [23:0] CUR = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount, vcount;
    logic        bright, hsync_in, vsync_in;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cursor_en;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, blank_n_out, wr_err, clr_busy;

    always #5 clk = ~clk;

    vga_tile_renderer #(
        .H_OFFSET(160), .BG_COLOR(BG), .CURSOR_COLOR(CUR), .BLINK_LOG2(5)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_n_out(blank_n_out), .wr_err(wr_err), .clr_busy(clr_busy)
    );

    int          ncmp = 0;
    int          nfail = 0;
    logic [7:0]  mm [1200];
    int          fcnt = 0;
    bit          clearing = 1'b1;
    logic [23:0] last_rgb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] scale(input int v, input int bits);
        if (bits == 3) return 8'((v * 255 + 3) / 7);
        return 8'(v * 85);
    endfunction

    function automatic logic [23:0] expand(input logic [7:0] c);
        return {scale(int'(c[7:5]), 3), scale(int'(c[4:2]), 3),
                scale(int'(c[1:0]), 2)};
    endfunction

    function automatic logic [23:0] ref_pix(input int h, input int v,
            input bit b, input bit cen, input int ccol, input int crow);
        int x, col, row;
        if (!b) return 24'h0;
        if (clearing) return BG;
        x   = (h - 160 + 1024) % 1024;
        col = x / 16;
        row = (v / 16) % 32;
        if (cen && ((fcnt / 32) % 2 == 0) && col == ccol && row == crow &&
            (x % 16 == 0 || x % 16 == 15 || v % 16 == 0 || v % 16 == 15))
            return CUR;
        if (col < 40 && row < 30) return expand(mm[row * 40 + col]);
        return BG;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pix(input string tag, input int h, input int v,
                             input bit b);
        logic [23:0] e;
        hcount = 10'(h); vcount = 10'(v); bright = b;
        hsync_in = 1'b1; vsync_in = 1'b1;
        e = ref_pix(h, v, b, cursor_en, int'(cursor_col), int'(cursor_row));
        tick(); tick();
        last_rgb = {vga_r, vga_g, vga_b};
        chk(tag, {7'd0, blank_n_out, last_rgb}, {7'd0, b, e});
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        bit e;
        wr_en = 1'b1; wr_addr = 11'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        e = clearing || a >= 1200;
        if (!e) mm[a] = d;
        chk("wr_err_pulse", {31'd0, wr_err}, {31'd0, e});
        tick();
        chk("wr_err_clear", {31'd0, wr_err}, 32'd0);
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b0; tick(); tick();
        vsync_in = 1'b1; tick(); tick();
        fcnt++;
    endtask

    task automatic sweep_clear(input string tag);
        for (int k = 1; k <= 1200; k++) begin
            tick();
            if (k == 100) chk({tag, "_bg"}, {vga_r, vga_g, vga_b}, BG);
            if (k == 1199) chk({tag, "_busy"}, {31'd0, clr_busy}, 32'd1);
            if (k == 1200) chk({tag, "_done"}, {31'd0, clr_busy}, 32'd0);
        end
        clearing = 1'b0;
        foreach (mm[i]) mm[i] = 8'h00;
    endtask

    initial begin
        int h_q[$], v_q[$], b_q[$], hs_q[$], vs_q[$];
        int x, h, v, a, prev_vs;
        bit b;
        logic [23:0] e;

        rst = 1'b1; hcount = '0; vcount = '0; bright = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; cursor_en = 1'b0;
        cursor_col = '0; cursor_row = '0;
        tick(); tick();
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        chk("rst_sync", {29'd0, hsync_out, vsync_out, blank_n_out}, 32'd6);
        chk("rst_err_busy", {30'd0, wr_err, clr_busy}, 32'd1);

        // Clear sweep with a rejected write at clk 10
        rst = 1'b0; hcount = 10'd176; vcount = 10'd16; bright = 1'b1;
        wr_addr = 11'd5; wr_data = 8'hAA;
        for (int k = 1; k <= 1200; k++) begin
            wr_en = (k == 10);
            tick();
            wr_en = 1'b0;
            if (k >= 9 && k <= 12)
                chk("clr_wr_err", {31'd0, wr_err}, {31'd0, k == 10});
            if (k == 100) chk("clr_bg", {vga_r, vga_g, vga_b}, BG);
            if (k == 1199) chk("clr_busy", {31'd0, clr_busy}, 32'd1);
            if (k == 1200) chk("clr_done", {31'd0, clr_busy}, 32'd0);
        end
        clearing = 1'b0;
        foreach (mm[i]) mm[i] = 8'h00;
        check_pix("addr5_zero", 160 + 80, 0, 1'b1);
        chk("addr5_const", last_rgb, 24'h000000);

        do_write(41, 8'hE0);
        check_pix("red", 176, 16, 1'b1);
        chk("red_const", last_rgb, 24'hFF0000);
        do_write(41, 8'h03);
        check_pix("blue", 176, 16, 1'b1);
        chk("blue_const", last_rgb, 24'h0000FF);
        do_write(1200, 8'h55);
        check_pix("blue_kept", 180, 20, 1'b1);
        check_pix("cell0_kept", 160, 0, 1'b1);
        do_write(1199, 8'h1C);
        check_pix("green_lo", 784, 464, 1'b1);
        chk("green_const", last_rgb, 24'h00FF00);
        check_pix("green_hi", 799, 479, 1'b1);
        check_pix("unblanked", 784, 464, 1'b0);

        // Cursor outline and blink
        do_write(122, 8'h92);
        cursor_en = 1'b1; cursor_col = 6'd2; cursor_row = 5'd3;
        check_pix("cur_on", 192, 48, 1'b1);
        chk("cur_on_const", last_rgb, CUR);
        check_pix("cur_inner", 200, 56, 1'b1);
        check_pix("cur_corner", 207, 63, 1'b1);
        for (int i = 0; i < 32; i++) vsync_pulse();
        check_pix("cur_hidden", 192, 48, 1'b1);
        chk("cur_hidden_const", last_rgb, expand(8'h92));
        for (int i = 0; i < 32; i++) vsync_pulse();
        check_pix("cur_back", 192, 48, 1'b1);
        chk("cur_back_const", last_rgb, CUR);

        // Random map contents and pixels
        for (int i = 0; i < 40; i++) begin
            a = (i % 8 == 0) ? int'($urandom_range(1200, 2047))
                             : int'($urandom_range(0, 1199));
            do_write(a, 8'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            x = int'($urandom_range(0, 700));
            h = (x + 160) % 1024;
            v = int'($urandom_range(0, 520));
            b = ($urandom_range(0, 7) != 0);
            cursor_en = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cursor_col = 6'(x / 16);
                cursor_row = 5'((v / 16) % 32);
            end else begin
                cursor_col = 6'($urandom_range(0, 45));
                cursor_row = 5'($urandom_range(0, 31));
            end
            check_pix("rand_pix", h, v, b);
        end

        // Random per-clk sync/blank/position sweep, 2-clk alignment
        cursor_en = 1'b0;
        prev_vs = 1;
        for (int i = 0; i < 2000; i++) begin
            h = int'($urandom_range(0, 1023));
            v = int'($urandom_range(0, 1023));
            b = ($urandom_range(0, 3) != 0);
            hcount = 10'(h); vcount = 10'(v); bright = b;
            hsync_in = ($urandom_range(0, 3) != 0);
            vsync_in = ($urandom_range(0, 3) != 0);
            if (prev_vs == 1 && vsync_in == 1'b0) fcnt++;
            prev_vs = int'(vsync_in);
            h_q.push_back(h); v_q.push_back(v); b_q.push_back(int'(b));
            hs_q.push_back(int'(hsync_in)); vs_q.push_back(int'(vsync_in));
            tick();
            if (i >= 1) begin
                e = ref_pix(h_q[0], v_q[0], b_q[0] != 0, 1'b0, 0, 0);
                chk("sweep", {5'd0, hsync_out, vsync_out, blank_n_out,
                              vga_r, vga_g, vga_b},
                    {5'd0, hs_q[0] != 0, vs_q[0] != 0, b_q[0] != 0, e});
                void'(h_q.pop_front()); void'(v_q.pop_front());
                void'(b_q.pop_front()); void'(hs_q.pop_front());
                void'(vs_q.pop_front());
            end
        end
        hsync_in = 1'b1; vsync_in = 1'b1;

        // Reset in the middle of a sweep restarts it
        hcount = 10'd176; vcount = 10'd16; bright = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        clearing = 1'b1; fcnt = 0;
        for (int k = 0; k < 600; k++) tick();
        rst = 1'b1; tick();
        chk("rerst_busy", {31'd0, clr_busy}, 32'd1);
        rst = 1'b0;
        sweep_clear("rerst");
        check_pix("cleared41", 176, 16, 1'b1);
        chk("cleared41_const", last_rgb, 24'h000000);
        check_pix("cleared1199", 784, 464, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
